// File: rtl/rom_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_access_arbiter_if
//
// Bundles the request/grant/response signals shared between the two
// requesters and the ROM access arbiter.
//
// Parameters:
//   AW - ROM address width
//   DW - ROM data width
//
// Signals:
//   req0/addr0, req1/addr1 - per-port request and address (requester -> arbiter)
//   gnt0/gnt1              - one-cycle grant pulses (arbiter -> requester)
//   rdata                  - ROM read data, qualified by rvalid0/rvalid1
//   rvalid0/rvalid1        - one-cycle response pulses (arbiter -> requester)
//   busy                   - arbiter is serving a transaction
//
// Modports:
//   master - requester side (drives req/addr)
//   slave  - arbiter side (drives grant/response/busy)
// ---------------------------------------------------------------------------
interface rom_access_arbiter_if #(
    parameter int AW = 2,
    parameter int DW = 4
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] rdata;
    logic          rvalid0;
    logic          rvalid1;
    logic          busy;

    modport master (
        output req0, addr0, req1, addr1,
        input  gnt0, gnt1, rdata, rvalid0, rvalid1, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1,
        output gnt0, gnt1, rdata, rvalid0, rvalid1, busy
    );
endinterface

// File: rtl/rom_access_arbiter.sv
// ---------------------------------------------------------------------------
// rom_access_arbiter
//
// Shares a small internal LED code ROM between two requesters using
// round-robin arbitration. One transaction takes three cycles:
// IDLE (arbitrate, grant) -> READ (fetch ROM word) -> RESP (rvalid high).
//
// Parameters:
//   AW - ROM address width (2**AW entries)
//   DW - ROM data width
//
// Ports:
//   clk_2   - system clock, rising edge
//   reset_n - asynchronous reset, active low
//   bus     - rom_access_arbiter_if.slave (requests in, grants/data out)
//   cnt0/1  - 8-bit saturating grant counters, only when the macro
//             ROM_ACCESS_COUNT_EN is defined
//
// ROM content: ROM[i] = 3*(i+1), truncated to DW bits.
// ---------------------------------------------------------------------------
module rom_access_arbiter #(
    parameter int AW = 2,
    parameter int DW = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
`ifdef ROM_ACCESS_COUNT_EN
    output logic [7:0]            cnt0,
    output logic [7:0]            cnt1,
`endif
    rom_access_arbiter_if.slave   bus
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Constant lookup table, built one entry per generate iteration.
    logic [DW-1:0] w_rom [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
            assign w_rom[gi] = DW'(3 * (gi + 1));
        end
    endgenerate

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_addr_q, w_addr_next;
    logic          r_sel_q, w_sel_next;        // 0 = port 0, 1 = port 1
    logic          r_last_winner, w_last_next;
    logic          r_gnt0, w_gnt0_next;
    logic          r_gnt1, w_gnt1_next;
    logic          r_rvalid0, w_rvalid0_next;
    logic          r_rvalid1, w_rvalid1_next;
    logic [DW-1:0] r_rdata, w_rdata_next;
    logic          w_winner;

    // Winner selection: a lone request wins outright; on a tie the port that
    // did not win last time is chosen.
    always_comb begin
        w_winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_winner = ~r_last_winner;
        end else if (bus.req1) begin
            w_winner = 1'b1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr_q;
        w_sel_next     = r_sel_q;
        w_last_next    = r_last_winner;
        w_rdata_next   = r_rdata;
        w_gnt0_next    = 1'b0;
        w_gnt1_next    = 1'b0;
        w_rvalid0_next = 1'b0;
        w_rvalid1_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_addr_next  = w_winner ? bus.addr1 : bus.addr0;
                    w_sel_next   = w_winner;
                    w_last_next  = w_winner;
                    w_gnt0_next  = ~w_winner;
                    w_gnt1_next  = w_winner;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_rdata_next   = w_rom[r_addr_q];
                w_rvalid0_next = ~r_sel_q;
                w_rvalid1_next = r_sel_q;
                w_state_next   = ST_RESP;
            end
            ST_RESP: begin
                // rvalid drops via the default; rdata holds.
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_addr_q      <= '0;
            r_sel_q       <= 1'b0;
            r_last_winner <= 1'b1;   // port 0 wins the first tie
            r_rdata       <= '0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_addr_q      <= w_addr_next;
            r_sel_q       <= w_sel_next;
            r_last_winner <= w_last_next;
            r_rdata       <= w_rdata_next;
            r_gnt0        <= w_gnt0_next;
            r_gnt1        <= w_gnt1_next;
            r_rvalid0     <= w_rvalid0_next;
            r_rvalid1     <= w_rvalid1_next;
        end
    end

    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata   = r_rdata;
    assign bus.busy    = (r_state != ST_IDLE);

`ifdef ROM_ACCESS_COUNT_EN
    logic [7:0] r_cnt0, r_cnt1;

    // Count grant pulses, saturating at 0xFF.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt0 <= 8'h00;
            r_cnt1 <= 8'h00;
        end else begin
            if (r_gnt0 && (r_cnt0 != 8'hFF)) begin
                r_cnt0 <= r_cnt0 + 8'd1;
            end
            if (r_gnt1 && (r_cnt1 != 8'hFF)) begin
                r_cnt1 <= r_cnt1 + 8'd1;
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_rom_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_access_arbiter
//
// Directed, table-driven bench for rom_access_arbiter (AW=2, DW=4).
// Each table row gives the inputs held across one rising edge and the
// outputs expected just after that edge, packed as
// {gnt0, gnt1, rvalid0, rvalid1, busy, rdata[3:0]}.
// Reset behaviour and the grant counters are exercised by hand sequences.
// ---------------------------------------------------------------------------
module tb_rom_access_arbiter;

    logic clk_2;
    logic reset_n;

    rom_access_arbiter_if #(.AW(2), .DW(4)) bus ();

`ifdef ROM_ACCESS_COUNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    rom_access_arbiter #(.AW(2), .DW(4)) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
`ifdef ROM_ACCESS_COUNT_EN
        .cnt0    (cnt0),
        .cnt1    (cnt1),
`endif
        .bus     (bus)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    typedef struct {
        logic       req0;
        logic [1:0] addr0;
        logic       req1;
        logic [1:0] addr1;
        logic [8:0] exp;
    } vec_t;

    vec_t vq[$];
    int   total;
    int   bad;

    function automatic logic [8:0] outs();
        return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy, bus.rdata};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got g0g1v0v1b=%b rdata=%h, want g0g1v0v1b=%b rdata=%h",
                     name, act[8:4], act[3:0], exp[8:4], exp[3:0]);
        end else begin
            $display("ok   %s: g0g1v0v1b=%b rdata=%h", name, act[8:4], act[3:0]);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic drive(input logic r0, input logic [1:0] a0, input logic r1, input logic [1:0] a1);
        bus.req0  = r0;
        bus.addr0 = a0;
        bus.req1  = r1;
        bus.addr1 = a1;
    endtask

    task automatic add(input logic r0, input logic [1:0] a0, input logic r1, input logic [1:0] a1,
                       input logic [4:0] flags, input logic [3:0] d);
        vec_t v;
        v.req0  = r0;
        v.addr0 = a0;
        v.req1  = r1;
        v.addr1 = a1;
        v.exp   = {flags, d};
        vq.push_back(v);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        reset_n = 1'b0;

        // flags = {gnt0, gnt1, rvalid0, rvalid1, busy}
        // Alternating grants, both requesting continuously (addr0=0, addr1=3).
        add(1, 0, 1, 3, 5'b10001, 4'h0);
        add(1, 0, 1, 3, 5'b00101, 4'h3);
        add(1, 0, 1, 3, 5'b00000, 4'h3);
        add(1, 0, 1, 3, 5'b01001, 4'h3);
        add(1, 0, 1, 3, 5'b00011, 4'hC);
        add(1, 0, 1, 3, 5'b00000, 4'hC);
        add(1, 0, 1, 3, 5'b10001, 4'hC);
        add(1, 0, 1, 3, 5'b00101, 4'h3);
        add(1, 0, 1, 3, 5'b00000, 4'h3);
        add(1, 0, 1, 3, 5'b01001, 4'h3);
        add(0, 0, 0, 3, 5'b00011, 4'hC);
        add(0, 0, 0, 0, 5'b00000, 4'hC);
        // Single port 0 request, addr 2.
        add(1, 2, 0, 0, 5'b10001, 4'hC);
        add(0, 2, 0, 0, 5'b00101, 4'h9);
        add(0, 0, 0, 0, 5'b00000, 4'h9);
        // Port 1 raised while port 0 is being served: waits for IDLE.
        add(1, 0, 0, 0, 5'b10001, 4'h9);
        add(0, 0, 1, 1, 5'b00101, 4'h3);
        add(0, 0, 1, 1, 5'b00000, 4'h3);
        add(0, 0, 1, 1, 5'b01001, 4'h3);
        add(0, 0, 0, 1, 5'b00011, 4'h6);
        add(0, 0, 0, 0, 5'b00000, 4'h6);
        // Port 1 request raised while busy and dropped before IDLE: no effect.
        add(1, 3, 0, 0, 5'b10001, 4'h6);
        add(0, 3, 1, 2, 5'b00101, 4'hC);
        add(0, 0, 0, 2, 5'b00000, 4'hC);
        add(0, 0, 0, 0, 5'b00000, 4'hC);
        // Tie after a port 0 win goes to port 1.
        add(1, 1, 1, 0, 5'b01001, 4'hC);
        add(0, 1, 0, 0, 5'b00011, 4'h3);
        add(0, 0, 0, 0, 5'b00000, 4'h3);

        // Reset, then five idle cycles.
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("idle_after_reset[%0d]", i), outs(), 9'h000);
        end

        // Table-driven vectors.
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].req0, vq[i].addr0, vq[i].req1, vq[i].addr1);
            step();
            check($sformatf("vec[%0d]", i), outs(), vq[i].exp);
        end

        // Reset asserted during READ of a port 1 request.
        drive(1'b0, 2'd0, 1'b1, 2'd2);
        step();
        check("rst_mid_gnt1", outs(), {5'b01001, 4'h3});
        drive(1'b0, 2'd0, 1'b0, 2'd0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_async", outs(), 9'h000);
        step();
        check("rst_mid_held", outs(), 9'h000);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_mid_no_rvalid[%0d]", i), outs(), 9'h000);
        end
        drive(1'b1, 2'd1, 1'b1, 2'd3);
        step();
        check("post_rst_tie_gnt0", outs(), {5'b10001, 4'h0});
        drive(1'b0, 2'd1, 1'b0, 2'd3);
        step();
        check("post_rst_rvalid0", outs(), {5'b00101, 4'h6});
        step();
        check("post_rst_idle", outs(), {5'b00000, 4'h6});

`ifdef ROM_ACCESS_COUNT_EN
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 2'd0, 1'b0, 2'd0);
            step();
            drive(1'b0, 2'd0, 1'b0, 2'd0);
            step();
            step();
        end
        total++;
        if (cnt0 !== 8'hFF) begin
            bad++;
            $display("FAIL cnt0_saturated: got %h, want ff", cnt0);
        end else begin
            $display("ok   cnt0_saturated: %h", cnt0);
        end
        total++;
        if (cnt1 !== 8'h00) begin
            bad++;
            $display("FAIL cnt1_zero: got %h, want 00", cnt1);
        end else begin
            $display("ok   cnt1_zero: %h", cnt1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_access_arbiter.md
Name: rom_access_arbiter

Overview:
- Shares a single small lookup ROM between two requesters, port 0 and port 1.
- Uses round-robin arbitration with a registered request/grant/valid handshake.
- The ROM is internal and holds the LED code table.
- Sits between switch-driven request logic and the LED/LCD display path in the lab top level, so that only one requester reads the table per transaction.

Parameters:
- AW, 2, ROM address width; the ROM has 2**AW entries.
- DW, 4, ROM data width.

Ports:
- clk_2  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous reset, active low.
- req0  input  1  port 0 request; held high until gnt0 is seen.
- addr0  input  AW  port 0 address; must be stable while req0 is high.
- req1  input  1  port 1 request; same rules as req0.
- addr1  input  AW  port 1 address.
- gnt0  output  1  one-cycle pulse; port 0 won arbitration and addr0 was captured.
- gnt1  output  1  one-cycle pulse; port 1 won arbitration and addr1 was captured.
- rdata  output  DW  ROM read data; valid while rvalid0 or rvalid1 is high.
- rvalid0  output  1  one-cycle pulse; rdata belongs to port 0.
- rvalid1  output  1  one-cycle pulse; rdata belongs to port 1.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock is clk_2; reset_n is asynchronous and active low.
- Reset values: state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, busy=0, last_winner=1 (so port 0 wins the first tie).
- ROM content: ROM[i] = (3*(i+1)) truncated to DW bits. With defaults: 0->0x3, 1->0x6, 2->0x9, 3->0xC. The ROM is combinational and indexed by the captured address register.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - If neither req0 nor req1 is high, stay in IDLE.
  - If exactly one is high, that port wins.
  - If both are high, the port not equal to last_winner wins.
  - On the winning edge: capture that port's address into addr_q, set sel_q=winner, pulse gnt_winner for one cycle, update last_winner, go to READ.
- READ: rdata <= ROM[addr_q]; pulse rvalid_sel_q on the next cycle; go to RESP.
- RESP: rvalid pulse is high during this state; rdata holds its value. Next edge returns to IDLE and clears rvalid.
- Latency and throughput:
  - Request seen high at edge N -> gnt at cycle N+1 -> rvalid/rdata at cycle N+2.
  - Arbitration restarts at the edge after RESP, so the maximum rate is one access per 3 cycles.
- Requests arriving while busy=1 are ignored until the FSM returns to IDLE. They are not queued, but a held req is served then.
- A req dropped before gnt is never served and leaves no side effect.
- The requester must deassert req on the cycle after gnt. A req still high at the next IDLE is treated as a new request.
- gnt0 and gnt1 are never high together; the same holds for rvalid0 and rvalid1.
- rdata keeps its last value outside rvalid; it is reset to 0 only by reset_n.
- reset_n asserted mid-transaction: everything returns to reset values immediately. The pending rvalid is lost and last_winner=1.
- Address width: addresses are AW bits. All 2**AW entries exist, so there is no out-of-range case.

Optional Feature:
- Macro ROM_ACCESS_COUNT_EN.
- When defined, two output ports are added: cnt0 and cnt1, each 8 bits.
  - Each counter increments on its port's gnt pulse and saturates at 0xFF (no wrap).
  - Both are cleared by reset_n.
- When not defined, these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0x0.
- req0=1, addr0=2 for one request -> gnt0 pulses at cycle 1, rvalid0 at cycle 2 with rdata=0x9; port 1 outputs stay 0.
- req0=req1=1 continuously with addr0=0, addr1=3 -> grant order port0, port1, port0, port1. rdata sequence is 0x3, 0xC, 0x3, 0xC, with 3 cycles between grants.
- req1 raised while busy serving port 0 (addr1=1) -> gnt1 only after port 0's RESP cycle; rvalid1 follows with rdata=0x6.
- reset_n pulled low during READ of a port 1 request -> rvalid1 never pulses and outputs return to reset values. Simultaneous requests after reset grant port 0 first.
- With ROM_ACCESS_COUNT_EN: 300 back-to-back port 0 requests -> cnt0=0xFF (saturated) and cnt1=0x00.
